// File: rtl/fir_output_requantizer.sv
// Requantizes the 32-bit fir_filter output stream to 16 bits (round-half-up, shift, saturate),
// optionally decimates, and buffers the results in a small first-word-fall-through FIFO.
module fir_output_requantizer #(
    parameter int SHIFT      = 4,
    parameter int DECIM      = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              valid_in,
    input  logic [31:0]                       signal_in,
    input  logic                              out_ready,
    output logic                              out_valid,
    output logic [15:0]                       out_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              sat_flag,
    output logic                              overflow,
    input  logic                              clear_flags
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int PH_W  = 5;
    localparam logic [32:0]      ROUND   = (33'd1 << SHIFT) >> 1;
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(DECIM - 1);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(FIFO_DEPTH);

    if (SHIFT < 0 || SHIFT > 16) begin : g_bad_shift
        $error("fir_output_requantizer: SHIFT must be in 0..16");
    end
    if (DECIM < 1 || DECIM > 16) begin : g_bad_decim
        $error("fir_output_requantizer: DECIM must be in 1..16");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fir_output_requantizer: FIFO_DEPTH must be a power of 2 and at least 2");
    end

    // ------------------------------------------------------------------
    // Rescale: 33-bit datapath so the rounding add of 0xFFFFFFFF cannot wrap.
    // ------------------------------------------------------------------
    logic [32:0] sum;
    logic [32:0] scaled;
    logic        sat;
    logic [15:0] result;

    always_comb begin
        sum    = {1'b0, signal_in} + ROUND;
        scaled = sum >> SHIFT;
        sat    = (scaled > 33'h0_0000_FFFF);
        result = sat ? 16'hFFFF : scaled[15:0];
    end

    // ------------------------------------------------------------------
    // Decimation phase: only advanced by real samples, so idle gaps are invisible.
    // ------------------------------------------------------------------
    logic [PH_W-1:0] phase_q, phase_d;
    logic            keep;

    always_comb begin
        keep    = valid_in && (phase_q == '0);
        phase_d = phase_q;
        if (valid_in) begin
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 register
    // ------------------------------------------------------------------
    logic        s1_valid_q, s1_valid_d;
    logic [15:0] s1_data_q, s1_data_d;
    logic        s1_sat_q, s1_sat_d;

    always_comb begin
        s1_valid_d = keep;
        s1_data_d  = s1_data_q;
        s1_sat_d   = s1_sat_q;
        if (keep) begin
            s1_data_d = result;
            s1_sat_d  = sat;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO control
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             empty, full, pop, push, drop;

    always_comb begin
        empty = (level_q == '0);
        full  = (level_q == LVL_MAX);
        pop   = !empty && out_ready;
        // A full FIFO still accepts a push when the head leaves on the same edge.
        push  = s1_valid_q && (!full || pop);
        drop  = s1_valid_q && full && !pop;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage array is not reset; level gates every read of it.
    logic [15:0] mem_q [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s1_data_q;
        end
    end

    // ------------------------------------------------------------------
    // Sticky flags: a set event in the same cycle as clear_flags wins.
    // ------------------------------------------------------------------
    logic sat_flag_q, sat_flag_d;
    logic overflow_q, overflow_d;

    always_comb begin
        sat_flag_d = clear_flags ? 1'b0 : sat_flag_q;
        overflow_d = clear_flags ? 1'b0 : overflow_q;
        if (push && s1_sat_q) begin
            sat_flag_d = 1'b1;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_sat_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            sat_flag_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_sat_q   <= s1_sat_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            sat_flag_q <= sat_flag_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        out_valid  = !empty;
        out_data   = empty ? 16'h0000 : mem_q[rd_ptr_q];
        fifo_level = level_q;
        sat_flag   = sat_flag_q;
        overflow   = overflow_q;
    end

endmodule

// File: tb/tb_fir_output_requantizer.sv
// Checks two requantizer instances (DECIM=1 and DECIM=3, SHIFT=4, depth 4) against a
// queue-based behavioural model every cycle, plus literal expectations for the key scenarios.
module tb_fir_output_requantizer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        valid_in;
    logic [31:0] signal_in;
    logic        out_ready;
    logic        clear_flags;

    logic [1:0]       ov;
    logic [1:0]       sf;
    logic [1:0]       of;
    logic [1:0][15:0] od;
    logic [1:0][2:0]  lvl;

    fir_output_requantizer #(.SHIFT(4), .DECIM(1), .FIFO_DEPTH(4)) dut_d1 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .signal_in(signal_in),
        .out_ready(out_ready), .out_valid(ov[0]), .out_data(od[0]),
        .fifo_level(lvl[0]), .sat_flag(sf[0]), .overflow(of[0]),
        .clear_flags(clear_flags)
    );

    fir_output_requantizer #(.SHIFT(4), .DECIM(3), .FIFO_DEPTH(4)) dut_d3 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .signal_in(signal_in),
        .out_ready(out_ready), .out_valid(ov[1]), .out_data(od[1]),
        .fifo_level(lvl[1]), .sat_flag(sf[1]), .overflow(of[1]),
        .clear_flags(clear_flags)
    );

    // ------------------------------------------------------------------
    // Behavioural model: queue of buffered samples, one pending sample in flight.
    // ------------------------------------------------------------------
    int unsigned mq   [2][$];
    int unsigned mlog [2][$];
    int unsigned mpop [2][$];
    bit          m_s1v [2];
    int unsigned m_s1d [2];
    bit          m_s1s [2];
    int          m_phase [2];
    bit          m_sat [2];
    bit          m_ovf [2];
    bit              m_pop, m_push;
    longint unsigned m_t;
    int unsigned     m_v;

    int total = 0;
    int bad   = 0;

    function automatic int dec(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mq[k].delete();
                m_s1v[k]   = 1'b0;
                m_phase[k] = 0;
                m_sat[k]   = 1'b0;
                m_ovf[k]   = 1'b0;
            end else begin
                m_pop  = (mq[k].size() != 0) && out_ready;
                m_push = m_s1v[k] && ((mq[k].size() < 4) || m_pop);
                if (clear_flags) begin
                    m_sat[k] = 1'b0;
                    m_ovf[k] = 1'b0;
                end
                if (m_pop) begin
                    m_v = mq[k].pop_front();
                    mpop[k].push_back(m_v);
                    $display("pop dec=%0d data=%04h t=%0t", dec(k), m_v, $time);
                end
                if (m_push) begin
                    mq[k].push_back(m_s1d[k]);
                    mlog[k].push_back(m_s1d[k]);
                    if (m_s1s[k]) m_sat[k] = 1'b1;
                end else if (m_s1v[k]) begin
                    m_ovf[k] = 1'b1;
                end
                m_s1v[k] = valid_in && (m_phase[k] == 0);
                m_t      = (longint'(signal_in) + 64'd8) / 64'd16;
                m_s1s[k] = (m_t > 64'd65535);
                m_s1d[k] = m_s1s[k] ? 32'd65535 : int'(m_t);
                if (valid_in) m_phase[k] = (m_phase[k] + 1) % dec(k);
            end
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic chk(string name, int k, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dec=%0d got=%0h want=%0h t=%0t", name, dec(k), act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            bit ev = (mq[k].size() != 0);
            chk("out_valid", k, ov[k], ev);
            if (ev) chk("out_data", k, od[k], mq[k][0]);
            chk("fifo_level", k, lvl[k], mq[k].size());
            chk("sat_flag", k, sf[k], m_sat[k]);
            chk("overflow", k, of[k], m_ovf[k]);
        end
    endtask

    // sel 0: sequence of pushed samples, sel 1: sequence of popped samples
    task automatic seq_chk(string name, int sel, int k, int base, int n,
                           int unsigned e0, int unsigned e1, int unsigned e2,
                           int unsigned e3, int unsigned e4);
        int unsigned e [5];
        int sz;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4;
        sz = (sel == 0) ? mlog[k].size() : mpop[k].size();
        chk({name, "_count"}, k, sz - base, n);
        for (int i = 0; i < n; i++) begin
            if (base + i < sz) begin
                chk(name, k, (sel == 0) ? mlog[k][base + i] : mpop[k][base + i], e[i]);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic send(logic [31:0] x);
        valid_in  = 1'b1;
        signal_in = x;
        tick();
        valid_in  = 1'b0;
    endtask

    task automatic idle(int n);
        valid_in = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    int b0, b1, p0;

    initial begin
        rst = 1'b1; valid_in = 1'b0; signal_in = '0; out_ready = 1'b1; clear_flags = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_out_valid", 0, ov[0], 0);
        chk("reset_out_data", 0, od[0], 0);
        chk("reset_level", 0, lvl[0], 0);
        chk("reset_sat", 0, sf[0], 0);
        chk("reset_ovf", 0, of[0], 0);

        // Rounding, with 2-cycle latency on the first sample
        b0 = mlog[0].size();
        valid_in = 1'b1; signal_in = 32'd20;
        tick();
        signal_in = 32'd100;
        tick();
        chk("latency_valid", 0, ov[0], 1);
        chk("latency_data", 0, od[0], 1);
        signal_in = 32'd200;
        tick();
        signal_in = 32'd170;
        tick();
        idle(4);
        seq_chk("rounding", 0, 0, b0, 4, 1, 6, 13, 11, 0);
        chk("rounding_sat", 0, sf[0], 0);

        // Saturation boundary and no wrap of the rounding add
        b0 = mlog[0].size();
        valid_in = 1'b1; signal_in = 32'h000F_FFF7;
        tick();
        signal_in = 32'h000F_FFF8;
        tick();
        chk("sat_exact_ffff", 0, sf[0], 0);
        signal_in = 32'hFFFF_FFFF;
        tick();
        chk("sat_rise", 0, sf[0], 1);
        idle(4);
        seq_chk("saturation", 0, 0, b0, 3, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 0);
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        chk("sat_cleared", 0, sf[0], 0);

        // Decimation by 3, back-to-back then with idle gaps
        do_reset();
        b1 = mlog[1].size();
        for (int i = 1; i <= 7; i++) send(32'(16 * i));
        idle(4);
        seq_chk("decim", 0, 1, b1, 3, 1, 4, 7, 0, 0);
        do_reset();
        b1 = mlog[1].size();
        for (int i = 1; i <= 7; i++) begin
            send(32'(16 * i));
            idle($urandom_range(0, 3));
        end
        idle(4);
        seq_chk("decim_gaps", 0, 1, b1, 3, 1, 4, 7, 0, 0);

        // Backpressure and overflow
        do_reset();
        out_ready = 1'b0;
        p0 = mpop[0].size();
        for (int i = 1; i <= 6; i++) send(32'(16 * i));
        idle(2);
        chk("bp_level", 0, lvl[0], 4);
        chk("bp_overflow", 0, of[0], 1);
        out_ready = 1'b1;
        idle(6);
        seq_chk("bp_drain", 1, 0, p0, 4, 1, 2, 3, 4, 0);
        chk("bp_empty", 0, ov[0], 0);

        // Full FIFO with simultaneous pop and push
        do_reset();
        out_ready = 1'b0;
        p0 = mpop[0].size();
        for (int i = 1; i <= 4; i++) send(32'(16 * i));
        idle(2);
        chk("full_level", 0, lvl[0], 4);
        valid_in = 1'b1; signal_in = 32'd80;
        tick();
        valid_in = 1'b0; out_ready = 1'b1;
        tick();
        chk("full_pop_level", 0, lvl[0], 4);
        chk("full_pop_ovf", 0, of[0], 0);
        idle(6);
        seq_chk("full_pop_drain", 1, 0, p0, 5, 1, 2, 3, 4, 5);

        // Reset mid-operation: level 3, sat set, DECIM=3 phase left non-zero
        do_reset();
        out_ready = 1'b0;
        send(32'hFFFF_FFFF);
        send(32'd16);
        send(32'd32);
        send(32'd48);
        idle(2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pre_rst_level", 0, lvl[0], 3);
        chk("pre_rst_sat", 0, sf[0], 1);
        do_reset();
        for (int k = 0; k < 2; k++) begin
            chk("rst_out_valid", k, ov[k], 0);
            chk("rst_out_data", k, od[k], 0);
            chk("rst_level", k, lvl[k], 0);
            chk("rst_sat", k, sf[k], 0);
            chk("rst_ovf", k, of[k], 0);
        end
        b0 = mlog[0].size();
        b1 = mlog[1].size();
        out_ready = 1'b1;
        send(32'd160);
        idle(3);
        seq_chk("after_rst", 0, 0, b0, 1, 10, 0, 0, 0, 0);
        seq_chk("after_rst", 0, 1, b1, 1, 10, 0, 0, 0, 0);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            valid_in = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: signal_in = $urandom_range(0, 4095);
                1: signal_in = 32'h000F_FFF0 + $urandom_range(0, 31);
                2: signal_in = $urandom;
                default: signal_in = 32'hFFFF_FFFF - $urandom_range(0, 15);
            endcase
            out_ready   = ($urandom_range(0, 9) < 6);
            clear_flags = ($urandom_range(0, 19) == 0);
            rst         = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst = 1'b0; valid_in = 1'b0; clear_flags = 1'b0; out_ready = 1'b1;
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
